// File: rtl/rcu_seq_pkg.sv
// ---------------------------------------------------------------------------
// rcu_seq_pkg
// Shared definitions for the reset-release sequencer (rcu_rst_seq) and its
// per-domain software-reset stretcher (rcu_rst_stretch).
//   seq_state_e  : sequencer states HOLD / REL / RUN
//   DEF_*        : default values of the sequencer parameters
//   dly_field()  : extract delay field k of width w from a flattened bus
// ---------------------------------------------------------------------------
package rcu_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_REL  = 2'd1,
    ST_RUN  = 2'd2
  } seq_state_e;

  localparam int DEF_NUM_DOM     = 4;
  localparam int DEF_DLY_WIDTH   = 8;
  localparam int DEF_HOLD_CYCLES = 16;

  // The helper works on a fixed-size container so it can serve any
  // NUM_DOM/DLY_WIDTH combination up to these limits.
  localparam int DLY_BUS_MAX   = 1024;
  localparam int DLY_FIELD_MAX = 32;

  function automatic logic [DLY_FIELD_MAX-1:0] dly_field(
    input logic [DLY_BUS_MAX-1:0] bus,
    input int                     k,
    input int                     w
  );
    logic [DLY_BUS_MAX-1:0]   shifted;
    logic [DLY_FIELD_MAX-1:0] mask;
    shifted = bus >> (k * w);
    mask    = (w >= DLY_FIELD_MAX) ? '1
            : ((DLY_FIELD_MAX'(1) << w) - DLY_FIELD_MAX'(1));
    return shifted[DLY_FIELD_MAX-1:0] & mask;
  endfunction

endpackage

// File: rtl/rcu_rst_stretch.sv
// ---------------------------------------------------------------------------
// rcu_rst_stretch
// Stretches a one-cycle software reset request into a HOLD_CYCLES-long
// active-low reset window for one domain. A new trigger during the window
// restarts it.
// Ports:
//   i_clk        clock
//   i_srst       synchronous active-high reset
//   i_trig       one-cycle software reset request
//   i_en         trigger qualifier (sequencer is in RUN)
//   i_clr        abort: clears the window immediately
//   o_low_next   domain must be held in reset after the coming edge; the
//                parent registers this into its reset output
// ---------------------------------------------------------------------------
module rcu_rst_stretch #(
  parameter int HOLD_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_srst,
  input  logic i_trig,
  input  logic i_en,
  input  logic i_clr,
  output logic o_low_next
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  // Counter holds the number of remaining low cycles including the one
  // that starts on the coming edge.
  always_comb begin
    w_cnt_next = r_cnt;
    if (i_clr) begin
      w_cnt_next = '0;
    end else if (i_en && i_trig) begin
      w_cnt_next = CNT_W'(HOLD_CYCLES);
    end else if (r_cnt != '0) begin
      w_cnt_next = r_cnt - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  assign o_low_next = (w_cnt_next != '0);

endmodule

// File: rtl/rcu_rst_seq.sv
// ---------------------------------------------------------------------------
// rcu_rst_seq
// Reset-release sequencer. Holds all downstream reset domains in reset until
// the PLL has been locked for HOLD_CYCLES consecutive cycles, then releases
// the domains in index order with a programmable delay per stage. In RUN it
// services per-domain software reset pulses; a global request or PLL lock
// loss aborts back to HOLD.
// Ports:
//   clk_i          system clock
//   rst_i          synchronous active-high reset
//   pll_lock_i     PLL lock (already synchronised)
//   dly_i          per-stage delays, field k = dly_i[k*DLY_WIDTH +: DLY_WIDTH]
//   sw_rst_i       one-cycle software reset request per domain
//   glb_rst_req_i  global reset request
//   dom_rst_n_o    per-domain active-low reset (registered)
//   stage_o        index of the domain currently being released
//   busy_o         high outside RUN
//   done_o         high in RUN
// ---------------------------------------------------------------------------
module rcu_rst_seq
  import rcu_seq_pkg::*;
#(
  parameter int NUM_DOM     = DEF_NUM_DOM,
  parameter int DLY_WIDTH   = DEF_DLY_WIDTH,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           pll_lock_i,
  input  logic [NUM_DOM*DLY_WIDTH-1:0]   dly_i,
  input  logic [NUM_DOM-1:0]             sw_rst_i,
  input  logic                           glb_rst_req_i,
  output logic [NUM_DOM-1:0]             dom_rst_n_o,
  output logic [$clog2(NUM_DOM)-1:0]     stage_o,
  output logic                           busy_o,
  output logic                           done_o
);

  localparam int IDX_W  = $clog2(NUM_DOM);
  localparam int HCNT_W = $clog2(HOLD_CYCLES + 1);

  seq_state_e           r_state;
  seq_state_e           w_state_next;
  logic [HCNT_W-1:0]    r_hold_cnt;
  logic [HCNT_W-1:0]    w_hold_cnt_next;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     w_idx_next;
  logic [DLY_WIDTH-1:0] r_dly_cnt;
  logic [DLY_WIDTH-1:0] w_dly_cnt_next;
  logic [NUM_DOM-1:0]   r_rel;
  logic [NUM_DOM-1:0]   w_rel_next;
  logic [NUM_DOM-1:0]   r_dom_rst_n;
  logic [NUM_DOM-1:0]   w_dom_rst_n_next;
  logic [NUM_DOM-1:0]   w_sw_low_next;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_abort;
  logic                 w_run;
  logic [DLY_BUS_MAX-1:0] w_dly_bus;

  assign w_dly_bus = DLY_BUS_MAX'(dly_i);
  assign w_run     = (r_state == ST_RUN);
  // Lock loss only matters once sequencing has started; in HOLD it just
  // clears the lock streak.
  assign w_abort   = glb_rst_req_i | (~pll_lock_i & (r_state != ST_HOLD));

  always_comb begin
    w_state_next    = r_state;
    w_hold_cnt_next = r_hold_cnt;
    w_idx_next      = r_idx;
    w_dly_cnt_next  = r_dly_cnt;
    w_rel_next      = r_rel;
    if (w_abort) begin
      w_state_next    = ST_HOLD;
      w_hold_cnt_next = '0;
      w_idx_next      = '0;
      w_dly_cnt_next  = '0;
      w_rel_next      = '0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (pll_lock_i) begin
            if (r_hold_cnt == HCNT_W'(HOLD_CYCLES - 1)) begin
              w_state_next    = ST_REL;
              w_hold_cnt_next = '0;
              w_idx_next      = '0;
              w_dly_cnt_next  = DLY_WIDTH'(dly_field(w_dly_bus, 0, DLY_WIDTH));
            end else begin
              w_hold_cnt_next = r_hold_cnt + 1'b1;
            end
          end else begin
            w_hold_cnt_next = '0;
          end
        end
        ST_REL: begin
          if (r_dly_cnt != '0) begin
            w_dly_cnt_next = r_dly_cnt - 1'b1;
          end else begin
            w_rel_next[r_idx] = 1'b1;
            if (r_idx == IDX_W'(NUM_DOM - 1)) begin
              w_state_next = ST_RUN;
            end else begin
              // Next stage's delay is captured only here, on stage entry.
              w_idx_next     = r_idx + 1'b1;
              w_dly_cnt_next = DLY_WIDTH'(dly_field(w_dly_bus, int'(r_idx) + 1, DLY_WIDTH));
            end
          end
        end
        ST_RUN: begin
        end
        default: begin
          w_state_next = ST_HOLD;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DOM; gi++) begin : g_dom
      rcu_rst_stretch #(
        .HOLD_CYCLES (HOLD_CYCLES)
      ) u_stretch (
        .i_clk      (clk_i),
        .i_srst     (rst_i),
        .i_trig     (sw_rst_i[gi]),
        .i_en       (w_run),
        .i_clr      (w_abort),
        .o_low_next (w_sw_low_next[gi])
      );
      assign w_dom_rst_n_next[gi] = w_rel_next[gi] & ~w_sw_low_next[gi];
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_HOLD;
      r_hold_cnt  <= '0;
      r_idx       <= '0;
      r_dly_cnt   <= '0;
      r_rel       <= '0;
      r_dom_rst_n <= '0;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_hold_cnt  <= w_hold_cnt_next;
      r_idx       <= w_idx_next;
      r_dly_cnt   <= w_dly_cnt_next;
      r_rel       <= w_rel_next;
      r_dom_rst_n <= w_dom_rst_n_next;
      r_busy      <= (w_state_next != ST_RUN);
      r_done      <= (w_state_next == ST_RUN);
    end
  end

  assign dom_rst_n_o = r_dom_rst_n;
  assign stage_o     = r_idx;
  assign busy_o      = r_busy;
  assign done_o      = r_done;

endmodule
